emif_dfh_csr_mc: RTL



---
 rtl/emif_csr_pkg.sv | 25 ++
 rtl/emif_cal_sync_timer.sv | 53 +++++
 rtl/emif_dfh_csr_mc.sv | 127 ++++++++++++
 3 files changed

// File: rtl/emif_csr_pkg.sv
// emif_csr_pkg: shared types and register offsets for the multi-channel EMIF feature CSR block
package emif_csr_pkg;

    localparam logic [3:0]  EMIF_FEAT_TYPE          = 4'h3;
    localparam logic [15:0] EMIF_DFH_OFFSET         = 16'h0000;
    localparam logic [15:0] EMIF_STATUS_OFFSET      = 16'h0008;
    localparam logic [15:0] EMIF_CAPABILITY_OFFSET  = 16'h0010;
    localparam logic [15:0] EMIF_CAL_TIMEOUT_OFFSET = 16'h0018;

    typedef struct packed {
        logic [3:0]  feat_type;
        logic [18:0] rsvd;
        logic        eol;
        logic [23:0] next_offset;
        logic [3:0]  major_ver;
        logic [11:0] feat_id;
    } t_dfh;

    typedef enum logic [1:0] {
        MMIO_IDLE,
        MMIO_RD,
        MMIO_RESP
    } t_mmio_state;

endpackage

// File: rtl/emif_cal_sync_timer.sv
// emif_cal_sync_timer: per-channel calibration synchroniser, timeout counter and sticky timeout flag
module emif_cal_sync_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        success_a,
    input  logic        fail_a,
    input  logic [31:0] thresh,
    input  logic        clr,
    output logic        success_s,
    output logic        fail_s,
    output logic        timeout
);

    logic [1:0]  success_sync;
    logic [1:0]  fail_sync;
    logic [31:0] cnt;
    logic        run;

    assign success_s = success_sync[1];
    assign fail_s    = fail_sync[1];
    assign run       = enable && (thresh != 32'd0) && !success_s && !fail_s;

    // two-flop synchronisers for the asynchronous calibration results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            success_sync <= '0;
            fail_sync    <= '0;
        end else begin
            success_sync <= {success_sync[0], success_a};
            fail_sync    <= {fail_sync[0], fail_a};
        end
    end

    // count idle cycles; clear beats set, and >= lets a lowered threshold fire immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (clr) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
        end else if (!timeout) begin
            if (cnt >= thresh - 32'd1)
                timeout <= 1'b1;
            else
                cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/emif_dfh_csr_mc.sv
// emif_dfh_csr_mc: multi-channel EMIF DFH/status/capability/timeout CSRs behind a 64-bit MMIO port
module emif_dfh_csr_mc
    import emif_csr_pkg::*;
#(
    parameter int          NUM_CH          = 4,
    parameter logic [15:0] CH_MASK         = 16'h000F,
    parameter int          ADDR_W          = 16,
    parameter logic [11:0] FEAT_ID         = 12'h009,
    parameter logic [3:0]  DFH_MAJOR_VER   = 4'h1,
    parameter logic [23:0] NEXT_DFH_OFFSET = 24'h00B000,
    parameter logic        END_OF_LIST     = 1'b0,
    parameter logic [31:0] CAL_TIMEOUT_DEF = 32'd1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    input  logic [NUM_CH-1:0] cal_success,
    input  logic [NUM_CH-1:0] cal_fail,
    output logic              cal_err
);

    t_mmio_state       state, state_nxt;
    t_dfh              dfh;
    logic [31:0]       cal_timeout;
    logic [ADDR_W-1:0] rd_addr;
    logic [63:0]       rd_mux;
    logic [NUM_CH-1:0] success_s, fail_s, sticky, clr;
    logic              wr_en;
    logic              unused_wdata;

    function automatic logic hit(input logic [ADDR_W-1:0] a, input logic [15:0] off);
        return (a >> 3) == (ADDR_W'(off) >> 3);
    endfunction

    assign dfh          = '{feat_type: EMIF_FEAT_TYPE, rsvd: '0, eol: END_OF_LIST,
                            next_offset: NEXT_DFH_OFFSET, major_ver: DFH_MAJOR_VER, feat_id: FEAT_ID};
    assign wr_en        = req_valid && req_ready && req_write;
    assign clr          = (wr_en && hit(req_addr, EMIF_STATUS_OFFSET)) ? req_wdata[32 +: NUM_CH] : '0;
    assign unused_wdata = ^req_wdata;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        emif_cal_sync_timer u_timer (
            .clk       (clk),
            .rst       (rst),
            .enable    (CH_MASK[i]),
            .success_a (cal_success[i]),
            .fail_a    (cal_fail[i]),
            .thresh    (cal_timeout),
            .clr       (clr[i]),
            .success_s (success_s[i]),
            .fail_s    (fail_s[i]),
            .timeout   (sticky[i])
        );
    end

    // read decode of the latched address; unmapped words read as zero
    always_comb begin
        rd_mux = '0;
        if (hit(rd_addr, EMIF_DFH_OFFSET)) begin
            rd_mux = dfh;
        end else if (hit(rd_addr, EMIF_STATUS_OFFSET)) begin
            rd_mux[0 +: NUM_CH]  = success_s;
            rd_mux[16 +: NUM_CH] = fail_s;
            rd_mux[32 +: NUM_CH] = sticky;
        end else if (hit(rd_addr, EMIF_CAPABILITY_OFFSET)) begin
            rd_mux[15:0]  = CH_MASK;
            rd_mux[19:16] = 4'(NUM_CH - 1);
        end else if (hit(rd_addr, EMIF_CAL_TIMEOUT_OFFSET)) begin
            rd_mux[31:0] = cal_timeout;
        end
    end

    // MMIO state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= MMIO_IDLE;
        else
            state <= state_nxt;
    end

    // MMIO next state and handshake outputs; one request outstanding at a time
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            MMIO_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !req_write)
                    state_nxt = MMIO_RD;
            end
            MMIO_RD:   state_nxt = MMIO_RESP;
            MMIO_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = MMIO_IDLE;
            end
            default:   state_nxt = MMIO_IDLE;
        endcase
    end

    // read address capture, registered read data, timeout register and error aggregation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr     <= '0;
            rsp_rdata   <= '0;
            cal_timeout <= CAL_TIMEOUT_DEF;
            cal_err     <= 1'b0;
        end else begin
            if (req_valid && req_ready && !req_write)
                rd_addr <= req_addr;
            if (state == MMIO_RD)
                rsp_rdata <= rd_mux;
            if (wr_en && hit(req_addr, EMIF_CAL_TIMEOUT_OFFSET))
                cal_timeout <= req_wdata[31:0];
            cal_err <= |{fail_s, sticky};
        end
    end

endmodule
